// File: rtl/seq_mult_radix_if.sv
// Operand/result handshake bundle for seq_mult_radix: valid/ready on the input and output sides.
interface seq_mult_radix_if #(
    parameter int W = 32
);
    logic           in_valid;
    logic           in_ready;
    logic           is_signed;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           busy;

    modport master (
        output in_valid, is_signed, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, is_signed, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/seq_mult_radix.sv
// Iterative sign/magnitude multiplier retiring R multiplier bits per clock, valid/ready on both sides.
// Optional early termination on an exhausted multiplier: define SEQ_MULT_EARLY_TERM_EN.
module seq_mult_radix #(
    parameter int W = 32,
    parameter int R = 2
) (
    input  logic           clk,
    input  logic           rst,
    seq_mult_radix_if.slave bus
);
    localparam int N  = W / R;
    localparam int CW = $clog2(N + 1);
    localparam int SW = $clog2(2 * W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [W-1:0]    r_a_mag;
    logic [W-1:0]    r_b_mag;
    logic            r_neg;
    logic [2*W-1:0]  r_acc;
    logic [2*W-1:0]  r_product;
    logic [CW-1:0]   r_count;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_last;
    logic [W-1:0]    w_a_mag;
    logic [W-1:0]    w_b_mag;
    logic            w_neg;
    logic [W+R-1:0]  w_pp;
    logic [SW-1:0]   w_shamt;
    logic [2*W-1:0]  w_pp_sh;
    logic [2*W-1:0]  w_acc_next;
    logic [2*W-1:0]  w_result;
    logic [W-1:0]    w_b_shift;

    // Magnitudes fit in W unsigned bits, including the most negative operand.
    assign w_a_mag = (bus.is_signed && bus.a[W-1]) ? -bus.a : bus.a;
    assign w_b_mag = (bus.is_signed && bus.b[W-1]) ? -bus.b : bus.b;
    assign w_neg   = bus.is_signed && (bus.a[W-1] ^ bus.b[W-1]);

    assign w_pp       = (W+R)'(r_a_mag) * (W+R)'(r_b_mag[R-1:0]);
    assign w_shamt    = SW'(r_count) * SW'(R);
    assign w_pp_sh    = (2*W)'(w_pp) << w_shamt;
    assign w_acc_next = r_acc + w_pp_sh;
    assign w_result   = r_neg ? -w_acc_next : w_acc_next;
    assign w_b_shift  = r_b_mag >> R;

`ifdef SEQ_MULT_EARLY_TERM_EN
    assign w_last = (r_count == CW'(N - 1)) || (w_b_shift == '0);
`else
    assign w_last = (r_count == CW'(N - 1));
`endif

    assign w_in_ready    = (r_state == IDLE) && !rst;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.product   = r_product;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.in_valid && w_in_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_mag   <= '0;
            r_b_mag   <= '0;
            r_neg     <= 1'b0;
            r_acc     <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_a_mag <= w_a_mag;
            r_b_mag <= w_b_mag;
            r_neg   <= w_neg;
            r_acc   <= '0;
            r_count <= '0;
        end else if (r_state == RUN) begin
            r_acc   <= w_acc_next;
            r_b_mag <= w_b_shift;
            r_count <= r_count + CW'(1);
            if (w_last) begin
                r_product <= w_result;
            end
        end
    end
endmodule

// File: tb/tb_seq_mult_radix.sv
// Scoreboard bench for seq_mult_radix: four instances (W8R2, W8R1, W8R4, W32R2) driven by directed vectors.
module tb_seq_mult_radix;
    typedef struct {
        logic [63:0] exp;
        int          lat;
    } exp_t;

    logic        clk;
    logic        t_rst       [4];
    logic        t_in_valid  [4];
    logic        t_is_signed [4];
    logic [31:0] t_a         [4];
    logic [31:0] t_b         [4];
    logic        t_out_ready [4];
    wire  [63:0] t_product   [4];
    wire         t_out_valid [4];
    wire         t_in_ready  [4];
    wire         t_busy      [4];

    exp_t sb [4][$];
    time  t_acc_time [4];
    time  t_hs;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            localparam int WI = (gi == 3) ? 32 : 8;
            localparam int RI = (gi == 1) ? 1 : ((gi == 2) ? 4 : 2);

            seq_mult_radix_if #(.W(WI)) bus ();

            assign bus.in_valid   = t_in_valid[gi];
            assign bus.is_signed  = t_is_signed[gi];
            assign bus.a          = t_a[gi][WI-1:0];
            assign bus.b          = t_b[gi][WI-1:0];
            assign bus.out_ready  = t_out_ready[gi];
            assign t_product[gi]  = 64'(bus.product);
            assign t_out_valid[gi] = bus.out_valid;
            assign t_in_ready[gi] = bus.in_ready;
            assign t_busy[gi]     = bus.busy;

            seq_mult_radix #(.W(WI), .R(RI)) u_dut (
                .clk (clk),
                .rst (t_rst[gi]),
                .bus (bus)
            );

            int   lat;
            logic seen;
            exp_t cur;

            always @(posedge clk) begin
                if (t_rst[gi] || (t_in_valid[gi] && t_in_ready[gi])) lat <= 0;
                else lat <= lat + 1;
            end

            // Monitor: first cycle of out_valid pops the scoreboard, later cycles check the held product.
            always @(negedge clk) begin
                chk($sformatf("in_ready_%0d", gi), 64'(t_in_ready[gi]), 64'(!t_busy[gi] && !t_rst[gi]));
                if (t_rst[gi] || !t_out_valid[gi]) begin
                    seen = 1'b0;
                end else begin
                    if (!seen) begin
                        if (sb[gi].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_out_%0d: got product %h required no output", gi, t_product[gi]);
                        end else begin
                            cur = sb[gi].pop_front();
                            chk($sformatf("product_%0d", gi), t_product[gi], cur.exp);
                            chk($sformatf("latency_%0d", gi), 64'(lat), 64'(cur.lat));
                            $display("txn dut=%0d product=%h latency=%0d", gi, t_product[gi], lat);
                        end
                        seen = 1'b1;
                    end else begin
                        chk($sformatf("held_product_%0d", gi), t_product[gi], cur.exp);
                    end
                    if (t_out_ready[gi]) seen = 1'b0;
                end
            end
        end
    endgenerate

    task automatic issue(input int k, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat_full, input int lat_et);
        exp_t e;
        int   n;
        e.exp = exp;
        e.lat = lat_full;
`ifdef SEQ_MULT_EARLY_TERM_EN
        e.lat = lat_et;
`endif
        n = 0;
        t_is_signed[k] = s;
        t_a[k]         = a;
        t_b[k]         = b;
        t_in_valid[k]  = 1'b1;
        while (!t_in_ready[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!t_in_ready[k]) begin
            chk($sformatf("accept_timeout_%0d", k), 64'(0), 64'(1));
            t_in_valid[k] = 1'b0;
            return;
        end
        @(posedge clk);
        sb[k].push_back(e);
        t_acc_time[k] = $time;
        @(negedge clk);
        t_in_valid[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while ((sb[k].size() != 0 || t_busy[k]) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb[k].size() != 0 || t_busy[k]) chk($sformatf("idle_timeout_%0d", k), 64'(0), 64'(1));
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        for (int k = 0; k < 4; k++) begin
            t_rst[k] = 1'b1;
            t_in_valid[k] = 1'b0;
            t_is_signed[k] = 1'b0;
            t_a[k] = '0;
            t_b[k] = '0;
            t_out_ready[k] = 1'b1;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("reset_product", t_product[k], 64'(0));
            chk("reset_out_valid", 64'(t_out_valid[k]), 64'(0));
            chk("reset_busy", 64'(t_busy[k]), 64'(0));
            t_rst[k] = 1'b0;
        end
        @(negedge clk);

        // Unsigned, signed corners and zero operands on W=8 R=2
        issue(0, 1'b0, 32'd200, 32'd250, 64'hC350, 4, 4);
        issue(0, 1'b1, 32'hFD, 32'h05, 64'hFFF1, 4, 2);
        issue(0, 1'b1, 32'h80, 32'h7F, 64'hC080, 4, 4);
        issue(0, 1'b1, 32'h80, 32'h80, 64'h4000, 4, 4);
        issue(0, 1'b1, 32'h00, 32'hFF, 64'h0000, 4, 1);
        issue(0, 1'b1, 32'hFF, 32'h00, 64'h0000, 4, 1);
        wait_idle(0);

        // Full-range unsigned at radix 2 and radix 16
        issue(1, 1'b0, 32'hFF, 32'hFF, 64'hFE01, 8, 8);
        issue(2, 1'b0, 32'hFF, 32'hFF, 64'hFE01, 2, 2);
        wait_idle(1);
        wait_idle(2);

        // Output backpressure with new operands waiting
        t_out_ready[0] = 1'b0;
        issue(0, 1'b0, 32'd12, 32'd13, 64'd156, 4, 2);
        n = 0;
        while (!t_out_valid[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", 64'(t_out_valid[0]), 64'(1));
        fork
            issue(0, 1'b0, 32'h0F, 32'h11, 64'h00FF, 4, 3);
            begin
                repeat (5) @(negedge clk);
                #2 t_out_ready[0] = 1'b1;
                @(posedge clk);
                t_hs = $time;
            end
        join
        chk("bp_accept_gap", 64'(t_acc_time[0] - t_hs), 64'(10));
        wait_idle(0);

        // Reset mid-operation on W=32 R=2
        issue(3, 1'b0, 32'd5, 32'd9, 64'd45, 16, 2);
        @(negedge clk);
        t_rst[3] = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(t_out_valid[3]), 64'(0));
        chk("midrst_product", t_product[3], 64'(0));
        chk("midrst_busy", 64'(t_busy[3]), 64'(0));
        sb[3].delete();
        @(negedge clk);
        t_rst[3] = 1'b0;
        @(negedge clk);
        issue(3, 1'b0, 32'd7, 32'd6, 64'd42, 16, 2);
        issue(3, 1'b0, 32'h1234, 32'h1, 64'h1234, 16, 1);
        issue(3, 1'b0, 32'h1234, 32'h10, 64'h12340, 16, 3);
        issue(3, 1'b1, 32'h80000000, 32'h7FFFFFFF, 64'hC000000080000000, 16, 16);
        issue(3, 1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000, 16, 16);
        issue(3, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 16, 16);
        wait_idle(3);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion before 200000");
        $fatal(1, "watchdog");
    end
endmodule
